shift_exec_unit: RTL and testbench

- Execute-stage wrapper that sits directly upstream of the combinational shifter in the CPU datapath. It accepts MIPS R-type shift instructions with their operand values over a valid/ready handshake.
- It decodes funct/shamt into the shifter's A/B/Shiftop inputs, instantiates the shifter, and buffers results in a small output FIFO for the writeback stage.
- Decouples the shifter from downstream stalls.

---
 rtl/shift_exec_unit.sv | 215 +++++++++++++++++++++
 tb/tb_shift_exec_unit.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_exec_unit.sv
// shift_exec_unit: execute-stage wrapper feeding the combinational shifter.
// Define SHIFT_ROTR_EN to add MIPS32r2 rotr/rotrv support.

module shift_exec_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [DATA_WIDTH-1:0] in_rs_val,
  input  logic [DATA_WIDTH-1:0] in_rt_val,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [4:0]            out_rd,
  output logic                  out_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rd;
  logic [4:0] shamt;
  logic       legal;

  assign opcode = in_instr[31:26];
  assign rd     = in_instr[15:11];
  assign shamt  = in_instr[10:6];
  assign funct  = in_instr[5:0];

  // Only R-type shift functs are executed here.
  always_comb begin
    legal = 1'b0;
    if (opcode == 6'h00) begin
      case (funct)
        6'h00, 6'h02, 6'h03,
        6'h04, 6'h06, 6'h07: legal = 1'b1;
        default:            legal = 1'b0;
      endcase
    end
  end

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_a_d;
  logic [4:0]            s1_b_q, s1_b_d;
  logic [1:0]            s1_op_q, s1_op_d;
  logic [4:0]            s1_rd_q, s1_rd_d;
  logic                  s1_err_q, s1_err_d;

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  logic pop;
  logic push;
  logic space;
  logic fire;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign space     = (count_q != FULL) || pop;
  assign push      = s1_valid_q && space;
  assign in_ready  = !s1_valid_q || push;
  assign fire      = in_valid && in_ready;

`ifdef SHIFT_ROTR_EN
  logic s1_rot_q, s1_rot_d;
  logic rot_dec;

  // bit 21 marks rotr, bit 6 marks rotrv
  assign rot_dec = legal && (funct[1:0] == 2'b10) &&
                   (funct[2] ? in_instr[6] : in_instr[21]);
`endif

  // S1 next state: load on handshake, clear once drained.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_rd_d    = s1_rd_q;
    s1_err_d   = s1_err_q;
`ifdef SHIFT_ROTR_EN
    s1_rot_d   = s1_rot_q;
`endif
    if (fire) begin
      s1_valid_d = 1'b1;
      s1_a_d     = in_rt_val;
      s1_b_d     = funct[2] ? in_rs_val[4:0] : shamt;
      s1_op_d    = funct[1:0];
      s1_rd_d    = rd;
      s1_err_d   = !legal;
`ifdef SHIFT_ROTR_EN
      s1_rot_d   = rot_dec;
`endif
    end else if (push) begin
      s1_valid_d = 1'b0;
    end
  end

  // S1 register; only the valid bit is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
    end
    s1_a_q   <= s1_a_d;
    s1_b_q   <= s1_b_d;
    s1_op_q  <= s1_op_d;
    s1_rd_q  <= s1_rd_d;
    s1_err_q <= s1_err_d;
`ifdef SHIFT_ROTR_EN
    s1_rot_q <= s1_rot_d;
`endif
  end

  logic [DATA_WIDTH-1:0] shift_y;
  logic [DATA_WIDTH-1:0] exec_res;
  logic [DATA_WIDTH-1:0] push_res;

  shifter #(.W(DATA_WIDTH)) u_shifter (
    .A       (s1_a_q),
    .B       (s1_b_q),
    .Shiftop (s1_op_q),
    .Y       (shift_y)
  );

`ifdef SHIFT_ROTR_EN
  logic [DATA_WIDTH-1:0] rot_left;

  // (0 - b) mod 32; for b==0 this is A<<0, and A|A == A
  assign rot_left = s1_a_q << (5'd0 - s1_b_q);
  assign exec_res = s1_rot_q ? (shift_y | rot_left) : shift_y;
`else
  assign exec_res = shift_y;
`endif

  assign push_res = s1_err_q ? '0 : exec_res;

  logic [DATA_WIDTH-1:0] mem_res_q [DEPTH];
  logic [4:0]            mem_rd_q  [DEPTH];
  logic                  mem_err_q [DEPTH];

  // FIFO pointer and occupancy next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // FIFO control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_res_q[wr_ptr_q] <= push_res;
      mem_rd_q[wr_ptr_q]  <= s1_rd_q;
      mem_err_q[wr_ptr_q] <= s1_err_q;
    end
  end

  assign out_result = out_valid ? mem_res_q[rd_ptr_q] : '0;
  assign out_rd     = out_valid ? mem_rd_q[rd_ptr_q]  : '0;
  assign out_err    = out_valid ? mem_err_q[rd_ptr_q] : 1'b0;

  logic unused_bits;
  assign unused_bits = ^{in_instr[25:16], in_rs_val[DATA_WIDTH-1:5]};

endmodule

module shifter #(
  parameter int W = 32
) (
  input  logic [W-1:0] A,
  input  logic [4:0]   B,
  input  logic [1:0]   Shiftop,
  output logic [W-1:0] Y
);

  // 00 left logical, 10 right logical, 11 right arithmetic.
  always_comb begin
    case (Shiftop)
      2'b00:   Y = A << B;
      2'b10:   Y = A >> B;
      2'b11:   Y = $signed(A) >>> B;
      default: Y = A;
    endcase
  end

endmodule

// File: tb/tb_shift_exec_unit.sv
// tb_shift_exec_unit: directed-vector bench for shift_exec_unit.
// Expected values are hand-computed per scenario.

module tb_shift_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_err;

  int vectors = 0;
  int miscompares = 0;

  shift_exec_unit #(.DATA_WIDTH(32), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_rs_val  (in_rs_val),
    .in_rt_val  (in_rt_val),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic [4:0] rd,
    input logic [4:0] sa,
    input logic [5:0] fn
  );
    return {6'h00, rs, rt, rd, sa, fn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] s_ins [8];
  logic [31:0] s_rs  [8];
  logic [31:0] s_rt  [8];
  logic        c_v   [12];
  logic [31:0] c_res [12];
  logic [4:0]  c_rd  [12];
  logic        c_err [12];
  logic        c_rdy [12];

  // Streams n ops with out_ready high and records outputs per slot.
  task automatic run_stream(input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n + 3; i++) begin
      in_valid = (i < n);
      if (i < n) begin
        in_instr  = s_ins[i];
        in_rs_val = s_rs[i];
        in_rt_val = s_rt[i];
      end
      @(negedge clk);
      c_v[i]   = out_valid;
      c_res[i] = out_result;
      c_rd[i]  = out_rd;
      c_err[i] = out_err;
      c_rdy[i] = in_ready;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({out_valid, in_ready, out_result, out_rd, out_err} !==
        {1'b0, 1'b1, 32'h0, 5'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: v=%0b rdy=%0b res=%h rd=%0d err=%0b, want 0 1 0 0 0",
               out_valid, in_ready, out_result, out_rd, out_err);
    end
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] er [2];
    logic [4:0]  ed [2];
    s_ins[0] = rtype(5'd0, 5'd2, 5'd3, 5'd31, 6'h00);
    s_rs[0] = 32'h0; s_rt[0] = 32'h0000_0001;
    er[0] = 32'h8000_0000; ed[0] = 5'd3;
    s_ins[1] = rtype(5'd0, 5'd2, 5'd4, 5'd4, 6'h03);
    s_rs[1] = 32'h0; s_rt[1] = 32'h8000_0000;
    er[1] = 32'hF800_0000; ed[1] = 5'd4;
    run_stream(2);
    for (int i = 0; i < 5; i++) begin
      logic ev;
      ev = (i >= 2) && (i < 4);
      vectors++;
      if (c_v[i] !== ev ||
          (ev && (c_res[i] !== er[i-2] || c_rd[i] !== ed[i-2] ||
                  c_err[i] !== 1'b0))) begin
        miscompares++;
        $display("FAIL basic slot %0d: v=%0b res=%h rd=%0d err=%0b, want v=%0b res=%h rd=%0d",
                 i, c_v[i], c_res[i], c_rd[i], c_err[i], ev,
                 ev ? er[i-2] : 32'h0, ev ? ed[i-2] : 5'd0);
      end
      if (i < 2) begin
        vectors++;
        if (c_rdy[i] !== 1'b1) begin
          miscompares++;
          $display("FAIL basic_ready slot %0d: got %0b want 1", i, c_rdy[i]);
        end
      end
    end
  endtask

  task automatic test_variable();
    logic [31:0] er [3];
    s_ins[0] = rtype(5'd1, 5'd2, 5'd1, 5'd0, 6'h06);
    s_rs[0] = 32'hFFFF_FFE4; s_rt[0] = 32'hF000_0000;
    er[0] = 32'h0F00_0000;
    s_ins[1] = rtype(5'd1, 5'd2, 5'd2, 5'd0, 6'h07);
    s_rs[1] = 32'hFFFF_FFE4; s_rt[1] = 32'hF000_0000;
    er[1] = 32'hFF00_0000;
    s_ins[2] = rtype(5'd1, 5'd2, 5'd3, 5'd7, 6'h04);
    s_rs[2] = 32'h0000_0020; s_rt[2] = 32'h0000_1234;
    er[2] = 32'h0000_1234;
    run_stream(3);
    for (int i = 2; i < 6; i++) begin
      logic ev;
      ev = (i < 5);
      vectors++;
      if (c_v[i] !== ev ||
          (ev && (c_res[i] !== er[i-2] || c_rd[i] !== 5'(i-1) ||
                  c_err[i] !== 1'b0))) begin
        miscompares++;
        $display("FAIL variable slot %0d: v=%0b res=%h rd=%0d err=%0b, want v=%0b res=%h rd=%0d",
                 i, c_v[i], c_res[i], c_rd[i], c_err[i], ev,
                 ev ? er[i-2] : 32'h0, i - 1);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] er [5];
    logic [4:0]  ed [5];
    logic        ee [5];
    s_ins[0] = rtype(5'd0, 5'd2, 5'd5, 5'd1, 6'h00);
    s_rs[0] = 32'h0; s_rt[0] = 32'h1;
    er[0] = 32'h2; ed[0] = 5'd5; ee[0] = 1'b0;
    s_ins[1] = rtype(5'd1, 5'd2, 5'd6, 5'd0, 6'h20);
    s_rs[1] = 32'h5; s_rt[1] = 32'h7;
    er[1] = 32'h0; ed[1] = 5'd6; ee[1] = 1'b1;
    s_ins[2] = rtype(5'd0, 5'd2, 5'd7, 5'd4, 6'h02);
    s_rs[2] = 32'h0; s_rt[2] = 32'h100;
    er[2] = 32'h10; ed[2] = 5'd7; ee[2] = 1'b0;
    s_ins[3] = {6'h08, 5'd1, 5'd2, 16'h4A5B};
    s_rs[3] = 32'h3; s_rt[3] = 32'hFFFF_FFFF;
    er[3] = 32'h0; ed[3] = 5'd9; ee[3] = 1'b1;
    s_ins[4] = rtype(5'd0, 5'd2, 5'd10, 5'd1, 6'h03);
    s_rs[4] = 32'h0; s_rt[4] = 32'h8000_0000;
    er[4] = 32'hC000_0000; ed[4] = 5'd10; ee[4] = 1'b0;
    run_stream(5);
    for (int i = 2; i < 8; i++) begin
      logic ev;
      ev = (i < 7);
      vectors++;
      if (c_v[i] !== ev ||
          (ev && (c_res[i] !== er[i-2] || c_rd[i] !== ed[i-2] ||
                  c_err[i] !== ee[i-2]))) begin
        miscompares++;
        $display("FAIL illegal slot %0d: v=%0b res=%h rd=%0d err=%0b, want v=%0b res=%h rd=%0d err=%0b",
                 i, c_v[i], c_res[i], c_rd[i], c_err[i], ev,
                 ev ? er[i-2] : 32'h0, ev ? ed[i-2] : 5'd0,
                 ev ? ee[i-2] : 1'b0);
      end
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_rs_val = 32'h0;
    in_rt_val = 32'h1;
    for (int k = 0; k < 3; k++) begin
      in_instr = rtype(5'd0, 5'd2, 5'(k + 1), 5'(k + 1), 6'h00);
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_fill op %0d: in_ready=%0b want 1", k, in_ready);
      end
      tick();
    end
    in_instr = rtype(5'd0, 5'd2, 5'd4, 5'd4, 6'h00);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      vectors++;
      if ({in_ready, out_valid, out_result, out_rd} !==
          {1'b0, 1'b1, 32'h2, 5'd1}) begin
        miscompares++;
        $display("FAIL stall_hold cyc %0d: rdy=%0b v=%0b res=%h rd=%0d, want 0 1 2 1",
                 j, in_ready, out_valid, out_result, out_rd);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_result !== (32'h2 << k) ||
          out_rd !== 5'(k + 1) || (k == 0 && in_ready !== 1'b1)) begin
        miscompares++;
        $display("FAIL stall_drain %0d: v=%0b res=%h rd=%0d rdy=%0b, want 1 %h %0d",
                 k, out_valid, out_result, out_rd, in_ready,
                 32'h2 << k, k + 1);
      end
      tick();
      in_valid = 1'b0;
    end
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_empty cyc %0d: v=%0b want 0", j, out_valid);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_rs_val = 32'h0;
    in_rt_val = 32'h1;
    for (int i = 0; i < 3; i++) begin
      in_instr = rtype(5'd0, 5'd2, 5'(i + 8), 5'(i), 6'h00);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 3; i < 7; i++) begin
      in_instr = rtype(5'd0, 5'd2, 5'(i + 8), 5'(i), 6'h00);
      @(negedge clk);
      vectors++;
      if ({in_ready, out_valid, out_result, out_rd} !==
          {1'b1, 1'b1, 32'h1 << (i - 3), 5'(i + 5)}) begin
        miscompares++;
        $display("FAIL b2b_stream %0d: rdy=%0b v=%0b res=%h rd=%0d, want 1 1 %h %0d",
                 i, in_ready, out_valid, out_result, out_rd,
                 32'h1 << (i - 3), i + 5);
      end
      tick();
    end
    in_valid = 1'b0;
    for (int i = 4; i < 8; i++) begin
      logic ev;
      ev = (i < 7);
      @(negedge clk);
      vectors++;
      if (out_valid !== ev ||
          (ev && (out_result !== (32'h1 << i) || out_rd !== 5'(i + 8)))) begin
        miscompares++;
        $display("FAIL b2b_drain %0d: v=%0b res=%h rd=%0d, want v=%0b res=%h",
                 i, out_valid, out_result, out_rd, ev, 32'h1 << i);
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_rs_val = 32'h0;
    in_rt_val = 32'h1;
    for (int i = 0; i < 3; i++) begin
      in_instr = rtype(5'd0, 5'd2, 5'(i + 16), 5'(i + 1), 6'h00);
      tick();
    end
    rst       = 1'b1;
    out_ready = 1'b1;
    in_instr  = rtype(5'd0, 5'd2, 5'd20, 5'd5, 6'h00);
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({out_valid, in_ready, out_result, out_rd, out_err} !==
        {1'b0, 1'b1, 32'h0, 5'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL midreset: v=%0b rdy=%0b res=%h rd=%0d err=%0b, want 0 1 0 0 0",
               out_valid, in_ready, out_result, out_rd, out_err);
    end
    for (int j = 0; j < 4; j++) begin
      tick();
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_stale cyc %0d: v=%0b res=%h rd=%0d, want v=0",
                 j, out_valid, out_result, out_rd);
      end
    end
    tick();
    in_valid  = 1'b1;
    in_rt_val = 32'h3;
    in_instr  = rtype(5'd0, 5'd2, 5'd21, 5'd2, 6'h00);
    tick();
    in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      logic ev;
      ev = (j == 1);
      @(negedge clk);
      vectors++;
      if (out_valid !== ev ||
          (ev && (out_result !== 32'hC || out_rd !== 5'd21))) begin
        miscompares++;
        $display("FAIL midreset_after %0d: v=%0b res=%h rd=%0d, want v=%0b res=0000000c rd=21",
                 j, out_valid, out_result, out_rd, ev);
      end
      tick();
    end
  endtask

  task automatic test_rotate();
    logic [31:0] er [4];
`ifdef SHIFT_ROTR_EN
    er[0] = 32'h7812_3456;
    er[1] = 32'h7812_3456;
`else
    er[0] = 32'h0012_3456;
    er[1] = 32'h0012_3456;
`endif
    er[2] = 32'h1234_5678;
    er[3] = 32'h0012_3456;
    s_ins[0] = rtype(5'd1, 5'd2, 5'd1, 5'd8, 6'h02);
    s_rs[0] = 32'h0; s_rt[0] = 32'h1234_5678;
    s_ins[1] = rtype(5'd3, 5'd2, 5'd2, 5'd1, 6'h06);
    s_rs[1] = 32'h8; s_rt[1] = 32'h1234_5678;
    s_ins[2] = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h02);
    s_rs[2] = 32'h0; s_rt[2] = 32'h1234_5678;
    s_ins[3] = rtype(5'd0, 5'd2, 5'd4, 5'd8, 6'h02);
    s_rs[3] = 32'h0; s_rt[3] = 32'h1234_5678;
    run_stream(4);
    for (int i = 2; i < 6; i++) begin
      vectors++;
      if (c_v[i] !== 1'b1 || c_res[i] !== er[i-2] ||
          c_rd[i] !== 5'(i - 1) || c_err[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL rotate slot %0d: v=%0b res=%h rd=%0d err=%0b, want 1 %h %0d 0",
                 i, c_v[i], c_res[i], c_rd[i], c_err[i], er[i-2], i - 1);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    in_rs_val = 32'h0;
    in_rt_val = 32'h0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_basic();
    test_variable();
    test_illegal();
    test_stall();
    test_back_to_back();
    test_reset_midflight();
    test_rotate();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
